// File: rtl/dqn_pkg.sv
// Shared definitions for the DQN grid-world training blocks: grid geometry,
// Q6.10 reward constants and the episode sequencer state encoding.
package dqn_pkg;

   localparam logic [3:0] GOAL_STATE = 4'd9;
   localparam logic [3:0] N_STATES   = 4'd10;
   localparam logic [3:0] MAX_STEP   = 4'd15;

   // Signed Q6.10 reward terms; every reward is a wrapping sum of these
   localparam logic [15:0] REW_P10  = 16'h2800;
   localparam logic [15:0] REW_M5   = 16'hEC00;
   localparam logic [15:0] REW_ZERO = 16'h0000;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ACT  = 3'd1,
      S_ENV  = 3'd2,
      S_CALC = 3'd3,
      S_EMIT = 3'd4
   } ep_state_t;

endpackage

// File: rtl/reward_module.sv
// Scores one grid transition. Reaching the goal earns +10, bumping a wall
// (next state equals current state) costs -5, and the last allowed step of
// an episode costs a further -5. Terms add in 16-bit Q6.10 without
// saturation, so the reachable values are +10, +5, 0, -5 and -10.
module reward_module
   import dqn_pkg::*;
(
   input  logic [3:0]  i_st,
   input  logic [3:0]  i_st1,
   input  logic [3:0]  i_step,
   output logic [15:0] o_reward
);

   logic [15:0] w_goalTerm;
   logic [15:0] w_bumpTerm;
   logic [15:0] w_stepTerm;

   // Pick each reward term independently, then sum them with plain wrap-around
   always_comb begin
      w_goalTerm = (i_st1 == GOAL_STATE) ? REW_P10 : REW_ZERO;
      w_bumpTerm = (i_st1 == i_st)       ? REW_M5  : REW_ZERO;
      w_stepTerm = (i_step == MAX_STEP)  ? REW_M5  : REW_ZERO;
      o_reward   = w_goalTerm + w_bumpTerm + w_stepTerm;
   end

endmodule

// File: rtl/episode_controller.sv
// Sequences DQN training episodes: asks the agent for an action, steps the
// environment, scores the transition and hands the tuple to the replay
// buffer. Owns the current state, step and episode counters.
module episode_controller
   import dqn_pkg::*;
#(
   parameter logic [3:0]      START_STATE = 4'd0,
   parameter int              EP_W        = 8,
   parameter logic [EP_W-1:0] N_EPISODES  = EP_W'(16)
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            stop,
   output logic            act_req,
   input  logic            act_valid,
   input  logic [1:0]      act_in,
   output logic            env_req,
   output logic [1:0]      act_o,
   input  logic            env_valid,
   input  logic [3:0]      env_st1,
   output logic            tr_valid,
   input  logic            tr_ready,
   output logic [3:0]      tr_st,
   output logic [3:0]      tr_st1,
   output logic [1:0]      tr_act,
   output logic [15:0]     tr_reward,
   output logic            tr_done,
   output logic [3:0]      st_o,
   output logic [3:0]      step_o,
   output logic [EP_W-1:0] ep_cnt,
   output logic            ep_done,
   output logic            busy,
   output logic            err
);

   ep_state_t       r_state;
   logic            r_actReq;
   logic            r_envReq;
   logic [1:0]      r_act;
   logic [3:0]      r_st;
   logic [3:0]      r_st1;
   logic [3:0]      r_step;
   logic [EP_W-1:0] r_epCnt;
   logic            r_epDone;
   logic            r_err;
   logic            r_trValid;
   logic [3:0]      r_trSt;
   logic [3:0]      r_trSt1;
   logic [1:0]      r_trAct;
   logic [15:0]     r_trReward;
   logic            r_trDone;

   logic [15:0]     w_reward;
   logic            w_done;
   logic [EP_W-1:0] w_epNext;
   logic            w_lastEpisode;
   logic            w_goIdle;

   reward_module u_reward (
      .i_st     (r_st),
      .i_st1    (r_st1),
      .i_step   (r_step),
      .o_reward (w_reward)
   );

   // Episode bookkeeping: terminal test, saturating episode count and the
   // decision whether an accepted tuple ends the run
   always_comb begin
      w_done        = (r_st1 == GOAL_STATE) || (r_step == MAX_STEP);
      w_epNext      = (&r_epCnt) ? r_epCnt : r_epCnt + EP_W'(1);
      w_lastEpisode = (N_EPISODES != '0) && (w_epNext == N_EPISODES);
      w_goIdle      = stop || (r_trDone && w_lastEpisode);
   end

   // Main sequencer; every handshake and tuple output is registered here
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_actReq   <= 1'b0;
         r_envReq   <= 1'b0;
         r_act      <= 2'd0;
         r_st       <= START_STATE;
         r_st1      <= 4'd0;
         r_step     <= 4'd0;
         r_epCnt    <= '0;
         r_epDone   <= 1'b0;
         r_err      <= 1'b0;
         r_trValid  <= 1'b0;
         r_trSt     <= 4'd0;
         r_trSt1    <= 4'd0;
         r_trAct    <= 2'd0;
         r_trReward <= 16'd0;
         r_trDone   <= 1'b0;
      end else begin
         r_epDone <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_st     <= START_STATE;
                  r_step   <= 4'd0;
                  r_epCnt  <= '0;
                  r_err    <= 1'b0;
                  r_actReq <= 1'b1;
                  r_state  <= S_ACT;
               end
            end
            S_ACT: begin
               if (act_valid) begin
                  r_act    <= act_in;
                  r_actReq <= 1'b0;
                  r_envReq <= 1'b1;
                  r_state  <= S_ENV;
               end
            end
            S_ENV: begin
               if (env_valid) begin
                  r_envReq <= 1'b0;
                  if (env_st1 >= N_STATES) begin
                     r_st1 <= r_st;
                     r_err <= 1'b1;
                  end else begin
                     r_st1 <= env_st1;
                  end
                  r_state <= S_CALC;
               end
            end
            S_CALC: begin
               r_trSt     <= r_st;
               r_trSt1    <= r_st1;
               r_trAct    <= r_act;
               r_trReward <= w_reward;
               r_trDone   <= w_done;
               r_trValid  <= 1'b1;
               r_state    <= S_EMIT;
            end
            S_EMIT: begin
               if (tr_ready) begin
                  r_trValid <= 1'b0;
                  if (r_trDone) begin
                     r_epDone <= 1'b1;
                     r_epCnt  <= w_epNext;
                     r_st     <= START_STATE;
                     r_step   <= 4'd0;
                  end else begin
                     r_st   <= r_st1;
                     r_step <= r_step + 4'd1;
                  end
                  if (w_goIdle) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_actReq <= 1'b1;
                     r_state  <= S_ACT;
                  end
               end
            end
            default: begin
               r_actReq  <= 1'b0;
               r_envReq  <= 1'b0;
               r_trValid <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

   assign act_req   = r_actReq;
   assign env_req   = r_envReq;
   assign act_o     = r_act;
   assign tr_valid  = r_trValid;
   assign tr_st     = r_trSt;
   assign tr_st1    = r_trSt1;
   assign tr_act    = r_trAct;
   assign tr_reward = r_trReward;
   assign tr_done   = r_trDone;
   assign st_o      = r_st;
   assign step_o    = r_step;
   assign ep_cnt    = r_epCnt;
   assign ep_done   = r_epDone;
   assign busy      = (r_state != S_IDLE);
   assign err       = r_err;

endmodule

// File: tb/tb_episode_controller.sv
// Directed bench for episode_controller, built with two episodes per run so
// the run-complete path is reachable in a short simulation.
module tb_episode_controller;

   logic        clk;
   logic        rst;
   logic        start;
   logic        stop;
   logic        act_req;
   logic        act_valid;
   logic [1:0]  act_in;
   logic        env_req;
   logic [1:0]  act_o;
   logic        env_valid;
   logic [3:0]  env_st1;
   logic        tr_valid;
   logic        tr_ready;
   logic [3:0]  tr_st;
   logic [3:0]  tr_st1;
   logic [1:0]  tr_act;
   logic [15:0] tr_reward;
   logic        tr_done;
   logic [3:0]  st_o;
   logic [3:0]  step_o;
   logic [7:0]  ep_cnt;
   logic        ep_done;
   logic        busy;
   logic        err;

   int checks = 0;
   int errors = 0;

   // Captured results of the most recent step
   logic [15:0] gRew;
   logic        gDone;
   logic [3:0]  gSt;
   logic [3:0]  gSt1;
   logic [1:0]  gAct;
   logic        gEnvNext;
   logic        gStable;
   logic        gEpDone;
   logic        gTimeout;

   episode_controller #(
      .START_STATE (4'd0),
      .EP_W        (8),
      .N_EPISODES  (8'd2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .act_req   (act_req),
      .act_valid (act_valid),
      .act_in    (act_in),
      .env_req   (env_req),
      .act_o     (act_o),
      .env_valid (env_valid),
      .env_st1   (env_st1),
      .tr_valid  (tr_valid),
      .tr_ready  (tr_ready),
      .tr_st     (tr_st),
      .tr_st1    (tr_st1),
      .tr_act    (tr_act),
      .tr_reward (tr_reward),
      .tr_done   (tr_done),
      .st_o      (st_o),
      .step_o    (step_o),
      .ep_cnt    (ep_cnt),
      .ep_done   (ep_done),
      .busy      (busy),
      .err       (err)
   );

   // Free-running clock, 10 time units per period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic applyStimulus_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Drives one full agent/environment/replay transaction. The agent answers
   // in the very cycle act_req is first seen, the replay buffer waits
   // holdCycles before accepting. Reports the tuple and whether everything
   // held still while the buffer stalled.
   task automatic applyStimulus_step(input logic [1:0] a, input logic [3:0] s1, input int holdCycles);
      int n;
      logic [3:0] stSnap;
      logic [3:0] stepSnap;
      logic [7:0] epSnap;
      gTimeout = 1'b0;
      gStable  = 1'b1;
      gEpDone  = 1'b0;
      gEnvNext = 1'b0;
      gRew = 16'hxxxx; gDone = 1'bx; gSt = 4'hx; gSt1 = 4'hx; gAct = 2'bxx;
      n = 0;
      while (!act_req && n < 50) begin @(negedge clk); n++; end
      if (!act_req) begin gTimeout = 1'b1; return; end
      act_valid = 1'b1;
      act_in    = a;
      @(negedge clk);
      act_valid = 1'b0;
      gEnvNext  = env_req;
      n = 0;
      while (!env_req && n < 50) begin @(negedge clk); n++; end
      if (!env_req) begin gTimeout = 1'b1; return; end
      env_valid = 1'b1;
      env_st1   = s1;
      @(negedge clk);
      env_valid = 1'b0;
      n = 0;
      while (!tr_valid && n < 50) begin @(negedge clk); n++; end
      if (!tr_valid) begin gTimeout = 1'b1; return; end
      gRew = tr_reward; gDone = tr_done; gSt = tr_st; gSt1 = tr_st1; gAct = tr_act;
      stSnap = st_o; stepSnap = step_o; epSnap = ep_cnt;
      for (int i = 0; i < holdCycles; i++) begin
         @(negedge clk);
         if (tr_valid !== 1'b1 || tr_reward !== gRew || tr_done !== gDone ||
             tr_st !== gSt || tr_st1 !== gSt1 || tr_act !== gAct ||
             st_o !== stSnap || step_o !== stepSnap || ep_cnt !== epSnap)
            gStable = 1'b0;
      end
      tr_ready = 1'b1;
      @(negedge clk);
      tr_ready = 1'b0;
      gEpDone  = ep_done;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (act_req !== 1'b0 || env_req !== 1'b0 || tr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_handshakes got=%b%b%b exp=000", act_req, env_req, tr_valid); end
      checks++; if (st_o !== 4'd0 || step_o !== 4'd0 || ep_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_counters got=%h/%h/%h exp=0/0/00", st_o, step_o, ep_cnt); end
      checks++; if (err !== 1'b0 || ep_done !== 1'b0 || tr_reward !== 16'h0000) begin errors++; $display("[TB] FAIL reset_misc got=%b/%b/%h exp=0/0/0000", err, ep_done, tr_reward); end
   endtask

   task automatic test_first_step();
      applyStimulus_start();
      checks++; if (busy !== 1'b1 || act_req !== 1'b1) begin errors++; $display("[TB] FAIL start_enter_act got=%b%b exp=11", busy, act_req); end
      applyStimulus_step(2'd1, 4'd2, 0);
      checks++; if (gTimeout !== 1'b0) begin errors++; $display("[TB] FAIL first_timeout got=%b exp=0", gTimeout); end
      checks++; if (gRew !== 16'h0000 || gDone !== 1'b0) begin errors++; $display("[TB] FAIL first_tuple got=%h/%b exp=0000/0", gRew, gDone); end
      checks++; if (gSt !== 4'd0 || gSt1 !== 4'd2 || gAct !== 2'd1) begin errors++; $display("[TB] FAIL first_fields got=%h/%h/%h exp=0/2/1", gSt, gSt1, gAct); end
      checks++; if (st_o !== 4'd2 || step_o !== 4'd1) begin errors++; $display("[TB] FAIL first_advance got=%h/%h exp=2/1", st_o, step_o); end
   endtask

   task automatic test_bump();
      applyStimulus_step(2'd3, 4'd2, 0);
      checks++; if (gTimeout !== 1'b0) begin errors++; $display("[TB] FAIL bump_timeout got=%b exp=0", gTimeout); end
      checks++; if (gRew !== 16'hEC00 || gDone !== 1'b0) begin errors++; $display("[TB] FAIL bump_reward got=%h/%b exp=ec00/0", gRew, gDone); end
      checks++; if (act_o !== 2'd3) begin errors++; $display("[TB] FAIL bump_act_o got=%h exp=3", act_o); end
   endtask

   task automatic test_back_to_back();
      applyStimulus_step(2'd2, 4'd3, 5);
      checks++; if (gTimeout !== 1'b0) begin errors++; $display("[TB] FAIL hold_timeout got=%b exp=0", gTimeout); end
      checks++; if (gEnvNext !== 1'b1) begin errors++; $display("[TB] FAIL same_cycle_act got=%b exp=1", gEnvNext); end
      checks++; if (gStable !== 1'b1) begin errors++; $display("[TB] FAIL hold_stable got=%b exp=1", gStable); end
      checks++; if (gRew !== 16'h0000 || st_o !== 4'd3 || step_o !== 4'd3) begin errors++; $display("[TB] FAIL hold_result got=%h/%h/%h exp=0000/3/3", gRew, st_o, step_o); end
   endtask

   task automatic test_goal();
      applyStimulus_step(2'd1, 4'd9, 0);
      checks++; if (gRew !== 16'h2800 || gDone !== 1'b1) begin errors++; $display("[TB] FAIL goal_tuple got=%h/%b exp=2800/1", gRew, gDone); end
      checks++; if (gEpDone !== 1'b1) begin errors++; $display("[TB] FAIL goal_ep_done got=%b exp=1", gEpDone); end
      checks++; if (ep_cnt !== 8'd1 || st_o !== 4'd0 || step_o !== 4'd0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL goal_after got=%h/%h/%h/%b exp=01/0/0/1", ep_cnt, st_o, step_o, busy); end
      @(negedge clk);
      checks++; if (ep_done !== 1'b0) begin errors++; $display("[TB] FAIL ep_done_pulse got=%b exp=0", ep_done); end
   endtask

   task automatic test_last_step_wall();
      for (int k = 0; k < 15; k++) begin
         applyStimulus_step(2'(k), (k == 14) ? 4'd8 : 4'(1 + (k % 7)), 0);
         checks++; if (gTimeout !== 1'b0 || gDone !== 1'b0) begin errors++; $display("[TB] FAIL walk_step%0d got=%b/%b exp=0/0", k, gTimeout, gDone); end
      end
      checks++; if (st_o !== 4'd8 || step_o !== 4'd15) begin errors++; $display("[TB] FAIL walk_position got=%h/%h exp=8/f", st_o, step_o); end
      applyStimulus_step(2'd0, 4'd8, 0);
      checks++; if (gRew !== 16'hD800 || gDone !== 1'b1 || gEpDone !== 1'b1) begin errors++; $display("[TB] FAIL last_wall got=%h/%b/%b exp=d800/1/1", gRew, gDone, gEpDone); end
      checks++; if (busy !== 1'b0 || ep_cnt !== 8'd2) begin errors++; $display("[TB] FAIL run_complete got=%b/%h exp=0/02", busy, ep_cnt); end
   endtask

   task automatic test_illegal_state();
      applyStimulus_start();
      checks++; if (ep_cnt !== 8'd0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL restart got=%h/%b exp=00/1", ep_cnt, busy); end
      applyStimulus_step(2'd2, 4'd4, 0);
      applyStimulus_step(2'd1, 4'd12, 0);
      checks++; if (gRew !== 16'hEC00 || gSt1 !== 4'd4) begin errors++; $display("[TB] FAIL illegal_sub got=%h/%h exp=ec00/4", gRew, gSt1); end
      checks++; if (err !== 1'b1 || st_o !== 4'd4 || step_o !== 4'd2) begin errors++; $display("[TB] FAIL illegal_err got=%b/%h/%h exp=1/4/2", err, st_o, step_o); end
      for (int k = 2; k < 15; k++) begin
         applyStimulus_step(2'd3, 4'(1 + (k % 7)), 0);
      end
      applyStimulus_step(2'd0, 4'd9, 0);
      checks++; if (gRew !== 16'h1400 || gDone !== 1'b1) begin errors++; $display("[TB] FAIL goal_last_step got=%h/%b exp=1400/1", gRew, gDone); end
      checks++; if (err !== 1'b1 || ep_cnt !== 8'd1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky got=%b/%h/%b exp=1/01/1", err, ep_cnt, busy); end
   endtask

   task automatic test_stop();
      stop = 1'b1;
      applyStimulus_step(2'd0, 4'd5, 0);
      stop = 1'b0;
      checks++; if (busy !== 1'b0 || st_o !== 4'd5 || step_o !== 4'd1) begin errors++; $display("[TB] FAIL stop_idle got=%b/%h/%h exp=0/5/1", busy, st_o, step_o); end
      checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL err_held_idle got=%b exp=1", err); end
      applyStimulus_start();
      checks++; if (err !== 1'b0 || st_o !== 4'd0 || step_o !== 4'd0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL start_clears got=%b/%h/%h/%b exp=0/0/0/1", err, st_o, step_o, busy); end
   endtask

   task automatic test_reset_mid_env();
      int n;
      n = 0;
      while (!act_req && n < 50) begin @(negedge clk); n++; end
      act_valid = 1'b1;
      act_in    = 2'd2;
      @(negedge clk);
      act_valid = 1'b0;
      checks++; if (env_req !== 1'b1) begin errors++; $display("[TB] FAIL reach_env got=%b exp=1", env_req); end
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++; if (busy !== 1'b0 || act_req !== 1'b0 || env_req !== 1'b0 || tr_valid !== 1'b0 || st_o !== 4'd0) begin errors++; $display("[TB] FAIL mid_env_reset got=%b%b%b%b/%h exp=0000/0", busy, act_req, env_req, tr_valid, st_o); end
      env_valid = 1'b1;
      env_st1   = 4'd3;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      env_valid = 1'b0;
      checks++; if (tr_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL no_partial_tuple got=%b/%b exp=0/0", tr_valid, busy); end
   endtask

   // Run every scenario in order, then report
   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0;
      act_valid = 1'b0; act_in = 2'd0;
      env_valid = 1'b0; env_st1 = 4'd0;
      tr_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_first_step();
      test_bump();
      test_back_to_back();
      test_goal();
      test_last_step_wall();
      test_illegal_state();
      test_stop();
      test_reset_mid_env();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard stop in case a wait ever escapes its bound
   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=running exp=finished");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
